// File: rtl/fetch_stage.sv
// fetch_stage: owns the PC, issues instruction-memory requests over a
// valid/ready style handshake (one outstanding request) and holds the IF/ID
// pipeline register feeding decode.
// Optional feature macro: FETCH_PERF_CNT_EN adds saturating performance
// counters for delivered fetches, stall cycles and accepted redirects.
module fetch_stage #(
   parameter int                     instr_width     = 32,
   parameter int                     pc_source_width = 2,
   parameter logic [instr_width-1:0] RESET_PC        = '0
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       stall_d,
   input  logic [pc_source_width-1:0] pc_src_d,
   input  logic [instr_width-1:0]     pc_branch_d,
   input  logic [instr_width-1:0]     imem_rdata,
   input  logic                       imem_valid,
   output logic                       imem_req,
   output logic [instr_width-1:0]     imem_addr,
   output logic [instr_width-1:0]     instr_d,
   output logic [instr_width-1:0]     pcplus4_d,
   output logic                       valid_d,
   output logic [instr_width-1:0]     pc_f
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]                perf_fetch_cnt,
   output logic [31:0]                perf_stall_cnt,
   output logic [31:0]                perf_flush_cnt
`endif
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [instr_width-1:0] pc_q, pc_d;
   logic [instr_width-1:0] ifidInstr_q, ifidInstr_d;
   logic [instr_width-1:0] ifidPc4_q, ifidPc4_d;
   logic                   ifidValid_q, ifidValid_d;
   logic [instr_width-1:0] holdInstr_q, holdInstr_d;
   logic [instr_width-1:0] holdPc4_q, holdPc4_d;
   logic [instr_width-1:0] redirPc_q, redirPc_d;
   logic                   redirPend_q, redirPend_d;

   logic                   redirAccept;
   logic [instr_width-1:0] redirTarget;
   logic [instr_width-1:0] jumpTarget;
   logic [instr_width-1:0] pcPlus4;

   // Decode's redirect only counts when decode is not stalled; jump beats branch.
   always_comb begin
      jumpTarget  = {ifidPc4_q[instr_width-1 -: 4], ifidInstr_q[instr_width-7:0], 2'b00};
      redirAccept = !stall_d && (|pc_src_d);
      redirTarget = pc_src_d[1] ? jumpTarget : pc_branch_d;
      pcPlus4     = pc_q + instr_width'(4);
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: a response that arrives under stall is parked in S_HOLD.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: state_d = S_REQ;
         S_REQ: begin
            if (imem_valid && !redirAccept && !redirPend_q && stall_d) begin
               state_d = S_HOLD;
            end
         end
         S_HOLD: begin
            if (!stall_d) begin
               state_d = S_REQ;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs: request only while in S_REQ, address is always the current PC.
   always_comb begin
      imem_req  = (state_q == S_REQ);
      imem_addr = pc_q;
      pc_f      = pc_q;
      instr_d   = ifidInstr_q;
      pcplus4_d = ifidPc4_q;
      valid_d   = ifidValid_q;
   end

   // Datapath next values: PC, IF/ID, hold buffer and the deferred redirect.
   always_comb begin
      pc_d        = pc_q;
      ifidInstr_d = ifidInstr_q;
      ifidPc4_d   = ifidPc4_q;
      ifidValid_d = ifidValid_q;
      holdInstr_d = holdInstr_q;
      holdPc4_d   = holdPc4_q;
      redirPc_d   = redirPc_q;
      redirPend_d = redirPend_q;
      case (state_q)
         S_IDLE: begin
            if (redirAccept) begin
               pc_d        = redirTarget;
               ifidInstr_d = '0;
               ifidValid_d = 1'b0;
            end
         end
         S_REQ: begin
            if (imem_valid) begin
               if (redirAccept) begin
                  pc_d        = redirTarget;
                  redirPend_d = 1'b0;
                  ifidInstr_d = '0;
                  ifidValid_d = 1'b0;
               end else if (redirPend_q) begin
                  pc_d        = redirPc_q;
                  redirPend_d = 1'b0;
                  ifidInstr_d = '0;
                  ifidValid_d = 1'b0;
               end else if (stall_d) begin
                  holdInstr_d = imem_rdata;
                  holdPc4_d   = pcPlus4;
               end else begin
                  ifidInstr_d = imem_rdata;
                  ifidPc4_d   = pcPlus4;
                  ifidValid_d = 1'b1;
                  pc_d        = pcPlus4;
               end
            end else if (redirAccept) begin
               redirPc_d   = redirTarget;
               redirPend_d = 1'b1;
               ifidInstr_d = '0;
               ifidValid_d = 1'b0;
            end
         end
         S_HOLD: begin
            if (!stall_d) begin
               if (redirAccept) begin
                  pc_d        = redirTarget;
                  ifidInstr_d = '0;
                  ifidValid_d = 1'b0;
               end else begin
                  ifidInstr_d = holdInstr_q;
                  ifidPc4_d   = holdPc4_q;
                  ifidValid_d = 1'b1;
                  pc_d        = holdPc4_q;
               end
            end
         end
         default: ;
      endcase
   end

   // Datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         pc_q        <= RESET_PC;
         ifidInstr_q <= '0;
         ifidPc4_q   <= '0;
         ifidValid_q <= 1'b0;
         holdInstr_q <= '0;
         holdPc4_q   <= '0;
         redirPc_q   <= '0;
         redirPend_q <= 1'b0;
      end else begin
         pc_q        <= pc_d;
         ifidInstr_q <= ifidInstr_d;
         ifidPc4_q   <= ifidPc4_d;
         ifidValid_q <= ifidValid_d;
         holdInstr_q <= holdInstr_d;
         holdPc4_q   <= holdPc4_d;
         redirPc_q   <= redirPc_d;
         redirPend_q <= redirPend_d;
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic        deliver;
   logic [31:0] fetchCnt_q, stallCnt_q, flushCnt_q;

   // A delivery is any cycle that loads a real instruction into IF/ID.
   always_comb begin
      deliver = ((state_q == S_REQ) && imem_valid && !stall_d && !redirAccept && !redirPend_q)
             || ((state_q == S_HOLD) && !stall_d && !redirAccept);
   end

   // Saturating event counters.
   always_ff @(posedge clk) begin
      if (!reset) begin
         fetchCnt_q <= '0;
         stallCnt_q <= '0;
         flushCnt_q <= '0;
      end else begin
         if (deliver && (fetchCnt_q != '1)) fetchCnt_q <= fetchCnt_q + 32'd1;
         if (stall_d && (stallCnt_q != '1)) stallCnt_q <= stallCnt_q + 32'd1;
         if (redirAccept && (flushCnt_q != '1)) flushCnt_q <= flushCnt_q + 32'd1;
      end
   end

   assign perf_fetch_cnt = fetchCnt_q;
   assign perf_stall_cnt = stallCnt_q;
   assign perf_flush_cnt = flushCnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenarios followed by randomized stimulus, all
// checked against a transaction-level model of the fetch stage kept here.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall_d;
   logic [1:0]  pc_src_d;
   logic [31:0] pc_branch_d;
   logic [31:0] imem_rdata;
   logic        imem_valid;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] instr_d;
   logic [31:0] pcplus4_d;
   logic        valid_d;
   logic [31:0] pc_f;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perfFetch, perfStall, perfFlush;
`endif

   always #5 clk = ~clk;

   fetch_stage dut (
      .clk         (clk),
      .reset       (reset),
      .stall_d     (stall_d),
      .pc_src_d    (pc_src_d),
      .pc_branch_d (pc_branch_d),
      .imem_rdata  (imem_rdata),
      .imem_valid  (imem_valid),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .instr_d     (instr_d),
      .pcplus4_d   (pcplus4_d),
      .valid_d     (valid_d),
      .pc_f        (pc_f)
`ifdef FETCH_PERF_CNT_EN
      ,
      .perf_fetch_cnt (perfFetch),
      .perf_stall_cnt (perfStall),
      .perf_flush_cnt (perfFlush)
`endif
   );

   int total = 0;
   int bad   = 0;
   bit checkEn = 1'b0;

   // Model state: what the stage must show, expressed as fetch transactions.
   logic [31:0] mPc = '0, mInstr = '0, mPc4 = '0, mHoldW = '0;
   bit          mValid = 1'b0;
   bit          mReq = 1'b0;
   bit          mHeld = 1'b0;
   logic [31:0] redirQ[$];

   // Memory responder state.
   int memWait = 0;
   int memLat  = 0;
   int fixLat  = 0;
   bit spurious = 1'b0;

   function automatic logic [31:0] memWord(input logic [31:0] a);
      case (a)
         32'h0000_0000: return 32'h2008_0005;
         32'h0000_0004: return 32'h2009_0007;
         32'h0000_0010: return 32'h1234_5678;
         32'h0000_0100: return 32'h0800_0010;
         default:       return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
      endcase
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic timeoutFail(input string name);
      total++;
      bad++;
      $display("[TB] FAIL %s: wait bound expired", name);
   endtask

   // One clock of the reference: apply the fetch rules to the sampled inputs.
   task automatic modelStep(input bit rstn, input bit stall, input logic [1:0] src,
                            input logic [31:0] br, input bit v, input logic [31:0] rd);
      bit          acc;
      logic [31:0] tgt;
      if (!rstn) begin
         mPc = '0; mInstr = '0; mPc4 = '0; mValid = 1'b0;
         mReq = 1'b0; mHeld = 1'b0; mHoldW = '0;
         redirQ.delete();
         return;
      end
      acc = !stall && (src != 2'b00);
      tgt = src[1] ? {mPc4[31:28], mInstr[25:0], 2'b00} : br;
      if (!mReq && !mHeld) begin
         mReq = 1'b1;
         if (acc) mPc = tgt;
      end else if (mHeld) begin
         if (!stall) begin
            mHeld = 1'b0;
            mReq  = 1'b1;
            if (acc) begin
               mPc = tgt;
            end else begin
               mInstr = mHoldW; mPc4 = mPc + 32'd4; mValid = 1'b1; mPc = mPc + 32'd4;
            end
         end
      end else if (v) begin
         if (acc) begin
            mPc = tgt;
         end else if (redirQ.size() != 0) begin
            mPc = redirQ.pop_front();
            mInstr = '0; mValid = 1'b0;
         end else if (stall) begin
            mHeld = 1'b1; mReq = 1'b0; mHoldW = rd;
         end else begin
            mInstr = rd; mPc4 = mPc + 32'd4; mValid = 1'b1; mPc = mPc + 32'd4;
         end
         redirQ.delete();
      end else if (acc) begin
         redirQ.delete();
         redirQ.push_back(tgt);
      end
      if (acc) begin
         mInstr = '0;
         mValid = 1'b0;
      end
   endtask

   // Drive one cycle of inputs (memory answers from the expected request), clock, update model.
   task automatic applyStimulus(input bit rstn, input bit stall, input logic [1:0] src,
                                input logic [31:0] br);
      bit          v;
      logic [31:0] rd;
      v  = 1'b0;
      rd = $urandom;
      if (mReq) begin
         if (memWait >= memLat) begin
            v       = 1'b1;
            rd      = memWord(mPc);
            memWait = 0;
            memLat  = (fixLat >= 0) ? fixLat : int'($urandom_range(0, 3));
         end else begin
            memWait++;
         end
      end else begin
         memWait = 0;
         if (spurious) v = 1'b1;
      end
      reset       = rstn;
      stall_d     = stall;
      pc_src_d    = src;
      pc_branch_d = br;
      imem_valid  = v;
      imem_rdata  = rd;
      @(posedge clk);
      modelStep(rstn, stall, src, br, v, rd);
      #1;
   endtask

   // Every cycle, all outputs must match the reference.
   always @(negedge clk) begin
      if (checkEn) begin
         checkOutput("pc_f",      pc_f,           mPc);
         checkOutput("imem_addr", imem_addr,      mPc);
         checkOutput("imem_req",  32'(imem_req),  32'(mReq));
         checkOutput("instr_d",   instr_d,        mInstr);
         checkOutput("pcplus4_d", pcplus4_d,      mPc4);
         checkOutput("valid_d",   32'(valid_d),   32'(mValid));
      end
   end

   initial begin
      int n;
      reset = 1'b0; stall_d = 1'b0; pc_src_d = 2'b00; pc_branch_d = '0;
      imem_valid = 1'b0; imem_rdata = '0;

      // Reset values.
      applyStimulus(1'b0, 1'b0, 2'b00, 32'h0);
      checkEn = 1'b1;
      checkOutput("rst_pc_f",   pc_f,          32'h0);
      checkOutput("rst_instr",  instr_d,       32'h0);
      checkOutput("rst_pc4",    pcplus4_d,     32'h0);
      checkOutput("rst_valid",  32'(valid_d),  32'h0);
      checkOutput("rst_req",    32'(imem_req), 32'h0);

      // Zero-wait memory streams two instructions.
      applyStimulus(1'b1, 1'b0, 2'b00, 32'h0);
      checkOutput("t1_req",  32'(imem_req), 32'h1);
      checkOutput("t1_addr", imem_addr,     32'h0);
      applyStimulus(1'b1, 1'b0, 2'b00, 32'h0);
      checkOutput("t1_instr0", instr_d,      32'h2008_0005);
      checkOutput("t1_pc4_0",  pcplus4_d,    32'h4);
      checkOutput("t1_valid0", 32'(valid_d), 32'h1);
      applyStimulus(1'b1, 1'b0, 2'b00, 32'h0);
      checkOutput("t1_instr1", instr_d,   32'h2009_0007);
      checkOutput("t1_pc4_1",  pcplus4_d, 32'h8);
      checkOutput("t1_pc_f",   pc_f,      32'h8);

      // Response for 0x10 arrives after 3 waits under stall, then released.
      applyStimulus(1'b1, 1'b0, 2'b00, 32'h0);
      fixLat = 3;
      applyStimulus(1'b1, 1'b0, 2'b00, 32'h0);
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 2'b00, 32'h0);
      checkOutput("t2_waiting_addr", imem_addr, 32'h10);
      applyStimulus(1'b1, 1'b1, 2'b00, 32'h0);
      checkOutput("t2_hold_req", 32'(imem_req), 32'h0);
      checkOutput("t2_hold_pc4", pcplus4_d,     32'h10);
      applyStimulus(1'b1, 1'b1, 2'b00, 32'h0);
      checkOutput("t2_hold_req2", 32'(imem_req), 32'h0);
      applyStimulus(1'b1, 1'b0, 2'b00, 32'h0);
      checkOutput("t2_rel_instr", instr_d,   32'h1234_5678);
      checkOutput("t2_rel_pc4",   pcplus4_d, 32'h14);
      checkOutput("t2_rel_addr",  imem_addr, 32'h14);

      // Branch accepted while waiting on 0x20.
      fixLat = 2;
      n = 0;
      while (mPc != 32'h20 && n < 40) begin applyStimulus(1'b1, 1'b0, 2'b00, 32'h0); n++; end
      if (n >= 40) timeoutFail("t3_reach_0x20");
      applyStimulus(1'b1, 1'b0, 2'b01, 32'h40);
      checkOutput("t3_addr_held",  imem_addr,    32'h20);
      checkOutput("t3_flush_vld",  32'(valid_d), 32'h0);
      applyStimulus(1'b1, 1'b0, 2'b00, 32'h0);
      checkOutput("t3_addr_held2", imem_addr,    32'h20);
      applyStimulus(1'b1, 1'b0, 2'b00, 32'h0);
      checkOutput("t3_new_addr",   imem_addr,    32'h40);
      checkOutput("t3_dropped",    32'(valid_d), 32'h0);

      // Jump target formation and jump-over-branch priority.
      fixLat = 0;
      applyStimulus(1'b1, 1'b0, 2'b01, 32'h100);
      n = 0;
      while (!(mValid && mPc4 == 32'h104) && n < 20) begin applyStimulus(1'b1, 1'b0, 2'b00, 32'h0); n++; end
      if (n >= 20) timeoutFail("t4_reach_0x100");
      checkOutput("t4_instr", instr_d,   32'h0800_0010);
      checkOutput("t4_pc4",   pcplus4_d, 32'h104);
      applyStimulus(1'b1, 1'b0, 2'b10, 32'h0);
      checkOutput("t4_jump_addr", imem_addr, 32'h40);
      applyStimulus(1'b1, 1'b0, 2'b01, 32'h100);
      checkOutput("t4_branch_addr", imem_addr, 32'h100);
      applyStimulus(1'b1, 1'b0, 2'b00, 32'h0);
      applyStimulus(1'b1, 1'b0, 2'b11, 32'h80);
      checkOutput("t4_jump_wins", imem_addr, 32'h40);

      // Redirect ignored under stall; reset mid-wait; late valid ignored.
      applyStimulus(1'b1, 1'b1, 2'b01, 32'h200);
      checkOutput("t5_stall_pc", pc_f, 32'h40);
      applyStimulus(1'b1, 1'b1, 2'b01, 32'h200);
      checkOutput("t5_stall_pc2", pc_f, 32'h40);
      fixLat = 3;
      applyStimulus(1'b1, 1'b0, 2'b00, 32'h0);
      checkOutput("t5_release_pc", pc_f, 32'h44);
      applyStimulus(1'b1, 1'b0, 2'b00, 32'h0);
      applyStimulus(1'b1, 1'b0, 2'b00, 32'h0);
      applyStimulus(1'b1, 1'b0, 2'b00, 32'h0);
      applyStimulus(1'b0, 1'b0, 2'b00, 32'h0);
      checkOutput("t5_rst_pc",    pc_f,          32'h0);
      checkOutput("t5_rst_instr", instr_d,       32'h0);
      checkOutput("t5_rst_valid", 32'(valid_d),  32'h0);
      checkOutput("t5_rst_req",   32'(imem_req), 32'h0);
      spurious = 1'b1;
      applyStimulus(1'b1, 1'b0, 2'b00, 32'h0);
      spurious = 1'b0;
      checkOutput("t5_late_valid", 32'(valid_d), 32'h0);
      checkOutput("t5_late_instr", instr_d,      32'h0);

      // PC wrap at the top of the address space.
      fixLat = 0;
      applyStimulus(1'b1, 1'b0, 2'b01, 32'hFFFF_FFFC);
      n = 0;
      while (!(mValid && mPc == 32'h0) && n < 20) begin applyStimulus(1'b1, 1'b0, 2'b00, 32'h0); n++; end
      if (n >= 20) timeoutFail("t6_reach_top");
      checkOutput("t6_pc4_wrap",  pcplus4_d, 32'h0);
      checkOutput("t6_addr_wrap", imem_addr, 32'h0);
      checkOutput("t6_instr",     instr_d,   memWord(32'hFFFF_FFFC));

      // Randomized traffic: latencies, stalls, redirects, stray valids, resets.
      fixLat = -1;
      for (int i = 0; i < 3000; i++) begin
         bit          r, s;
         logic [1:0]  src;
         r   = ($urandom_range(0, 79) != 0);
         s   = ($urandom_range(0, 3) == 0);
         src = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         spurious = ($urandom_range(0, 3) == 0);
         applyStimulus(r, s, src, $urandom & 32'hFFFF_FFFC);
      end

      @(negedge clk);
      checkEn = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
